// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS writeback path.
// wb_entry is the default writeback queue record: destination register and result value.
package mips_pkg;

    localparam int W          = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WBQ_DEPTH  = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [W-1:0]          data;
    } wb_entry;

endpackage

// File: rtl/wbq_fifo.sv
// Storage, pointers and occupancy for the writeback queue.
// Per-slot valid bits and destination addresses are exported for hazard lookup.
module wbq_fifo
    import mips_pkg::*;
#(
    parameter int  DEPTH   = WBQ_DEPTH,
    parameter type entry_t = wb_entry
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic                            push,
    input  entry_t                          push_entry,
    input  logic                            pop,
    output entry_t                          head_entry,
    output logic [DEPTH-1:0]                entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_addr,
    output logic                            full,
    output logic                            empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t           storage [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign head_entry = storage[head];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (do_push) begin
                tail              <= tail + 1'b1;
                entry_valid[tail] <= 1'b1;
            end
            if (do_pop) begin
                head              <= head + 1'b1;
                entry_valid[head] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset && do_push) begin
            storage[tail] <= push_entry;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_addr
        assign entry_addr[i] = storage[i].addr;
    end

endmodule

// File: rtl/writeback_queue.sv
// Register-file writeback queue: merges ALU and load results (load has priority),
// drops writes to $0, drains one entry per cycle and answers hazard queries.
module writeback_queue
    import mips_pkg::REG_ADDR_W, mips_pkg::WBQ_DEPTH;
#(
    parameter int W     = mips_pkg::W,
    parameter int DEPTH = WBQ_DEPTH
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [W-1:0]          alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_addr,
    input  logic [W-1:0]          mem_data,
    output logic                  mem_ready,
    output logic                  write_en,
    output logic [REG_ADDR_W-1:0] write_reg_addr,
    output logic [W-1:0]          write_reg_data,
    input  logic [REG_ADDR_W-1:0] chk_addr1,
    input  logic [REG_ADDR_W-1:0] chk_addr2,
    output logic                  chk_busy1,
    output logic                  chk_busy2,
    output logic                  full,
    output logic                  empty
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [W-1:0]          data;
    } entry_t;

    entry_t                           push_entry;
    entry_t                           head_entry;
    logic                             push;
    logic                             pop;
    logic                             mem_fire;
    logic                             alu_fire;
    logic [DEPTH-1:0]                 entry_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_addr;

    // Ready comes only from registered occupancy, so a same-cycle pop never frees a slot.
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;
    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;

    always_comb begin
        push_entry.addr = alu_addr;
        push_entry.data = alu_data;
        push            = alu_fire && (alu_addr != '0);
        if (mem_fire) begin
            push_entry.addr = mem_addr;
            push_entry.data = mem_data;
            push            = (mem_addr != '0);
        end
    end

    assign pop            = !empty;
    assign write_en       = !empty;
    assign write_reg_addr = head_entry.addr;
    assign write_reg_data = head_entry.data;

    always_comb begin
        chk_busy1 = 1'b0;
        chk_busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i] == chk_addr1)) chk_busy1 = 1'b1;
            if (entry_valid[i] && (entry_addr[i] == chk_addr2)) chk_busy2 = 1'b1;
        end
        if (chk_addr1 == '0) chk_busy1 = 1'b0;
        if (chk_addr2 == '0) chk_busy2 = 1'b0;
    end

    wbq_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .CLK         (CLK),
        .reset       (reset),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head_entry  (head_entry),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr),
        .full        (full),
        .empty       (empty)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: a list-of-pending-writes model predicts
// handshakes, flags and hazards; a monitor checks each register-file write in order.
module tb_writeback_queue;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]   addr;
        logic [W-1:0] data;
    } wr_t;

    logic         CLK = 1'b0;
    logic         reset = 1'b1;
    logic         alu_valid = 1'b0;
    logic [4:0]   alu_addr = '0;
    logic [W-1:0] alu_data = '0;
    logic         alu_ready;
    logic         mem_valid = 1'b0;
    logic [4:0]   mem_addr = '0;
    logic [W-1:0] mem_data = '0;
    logic         mem_ready;
    logic         write_en;
    logic [4:0]   write_reg_addr;
    logic [W-1:0] write_reg_data;
    logic [4:0]   chk_addr1 = '0;
    logic [4:0]   chk_addr2 = '0;
    logic         chk_busy1;
    logic         chk_busy2;
    logic         full;
    logic         empty;

    wr_t pending[$];
    wr_t expected[$];
    int  checks = 0;
    int  passed = 0;

    writeback_queue #(.W(W), .DEPTH(DEPTH)) dut (
        .CLK            (CLK),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_addr       (alu_addr),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .mem_valid      (mem_valid),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_ready      (mem_ready),
        .write_en       (write_en),
        .write_reg_addr (write_reg_addr),
        .write_reg_data (write_reg_data),
        .chk_addr1      (chk_addr1),
        .chk_addr2      (chk_addr2),
        .chk_busy1      (chk_busy1),
        .chk_busy2      (chk_busy2),
        .full           (full),
        .empty          (empty)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] required);
        checks++;
        if (actual === required) passed++;
        else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, actual, required, $time);
    endtask

    function automatic bit modelBusy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (pending[i]) if (pending[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive, compare combinational outputs with the model, then
    // advance the model across the coming edge (one write drains, at most one accept).
    task automatic applyStimulus(input bit mv, input logic [4:0] ma, input logic [W-1:0] md,
                                 input bit av, input logic [4:0] aa, input logic [W-1:0] ad,
                                 input logic [4:0] c1, input logic [4:0] c2);
        bit  m_full, m_empty, exp_mrdy, exp_ardy;
        wr_t w;
        @(negedge CLK);
        #1;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        chk_addr1 = c1; chk_addr2 = c2;
        #1;
        m_full   = (pending.size() == DEPTH);
        m_empty  = (pending.size() == 0);
        exp_mrdy = !m_full;
        exp_ardy = !m_full && !mv;
        checkOutput("mem_ready", mem_ready, exp_mrdy);
        checkOutput("alu_ready", alu_ready, exp_ardy);
        checkOutput("write_en", write_en, !m_empty);
        checkOutput("full", full, m_full);
        checkOutput("empty", empty, m_empty);
        checkOutput("chk_busy1", chk_busy1, modelBusy(c1));
        checkOutput("chk_busy2", chk_busy2, modelBusy(c2));
        if (!m_empty) void'(pending.pop_front());
        if (mv && exp_mrdy) begin
            w.addr = ma; w.data = md;
        end else if (av && exp_ardy) begin
            w.addr = aa; w.data = ad;
        end else begin
            w.addr = 5'd0; w.data = '0;
        end
        if (w.addr != 5'd0) begin
            pending.push_back(w);
            expected.push_back(w);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Anything queued when reset is raised is discarded, never written.
    task automatic applyReset(input int cycles);
        @(negedge CLK);
        #1;
        reset = 1'b1;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        pending.delete();
        expected.delete();
        repeat (cycles) @(negedge CLK);
        #1;
        reset = 1'b0;
    endtask

    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge CLK);
            if (write_en === 1'b1) begin
                if (expected.size() == 0) begin
                    checkOutput("spurious_write", write_en, 0);
                end else begin
                    e = expected.pop_front();
                    checkOutput("write_reg_addr", write_reg_addr, e.addr);
                    checkOutput("write_reg_data", write_reg_data, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [4:0]   ra, rb;
        logic [W-1:0] da, db;
        applyReset(2);

        // Single load, then drain.
        applyStimulus(1, 5'd5, 32'h1234, 0, 0, 0, 0, 0);
        idle(2);

        // Simultaneous offers: load wins, ALU retried next cycle.
        applyStimulus(1, 5'd4, 32'hB, 1, 5'd3, 32'hA, 0, 0);
        applyStimulus(0, 0, 0, 1, 5'd3, 32'hA, 0, 0);
        idle(2);

        // Six back-to-back ALU results, including a zero value.
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 0, 0, 1, 5'(10 + i), (i == 2) ? 32'h0 : 32'(32'h100 + i), 0, 0);
        idle(2);

        // Writes to $0 are accepted but never stored.
        applyStimulus(0, 0, 0, 1, 5'd0, 32'hFFFF, 0, 0);
        applyStimulus(1, 5'd0, 32'h55, 0, 0, 0, 0, 0);
        idle(2);

        // Hazard lookup on both ports, including $0 and drain.
        applyStimulus(1, 5'd7, 32'h77, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd7, 5'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd7, 5'd7);
        applyStimulus(1, 5'd9, 32'h99, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 5'd9);

        // Same destination twice: both writes, older first.
        applyStimulus(1, 5'd8, 32'h1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 5'd8, 32'h2, 5'd8, 0);
        idle(2);

        // Reset with traffic in flight.
        applyStimulus(1, 5'd1, 32'h11, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 5'd2, 32'h22, 0, 0);
        applyReset(1);
        idle(3);

        // Randomized traffic with occasional mid-stream resets.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                applyReset(1);
            end else begin
                ra = 5'($urandom_range(0, 7));
                rb = 5'($urandom_range(0, 31));
                da = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
                db = 32'($urandom);
                applyStimulus($urandom_range(0, 2) == 0, ra, da,
                              $urandom_range(0, 1) == 1, rb, db,
                              5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            end
        end
        idle(4);
        checkOutput("writes_outstanding", expected.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
